// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use interlock, branch flush, memory freeze and stall-cycle
// counter for the five-stage pipeline. Controls are combinational from inputs
// and state; only the FSM, bubble counter and stall counter are registered.
module hazard_ctrl #(
  parameter int unsigned RA_W     = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_ex_mr,
  input  logic             id_ex_rw,
  input  logic [RA_W-1:0]  id_ex_rd,
  input  logic [RA_W-1:0]  if_id_rs1,
  input  logic [RA_W-1:0]  if_id_rs2,
  input  logic             if_id_use1,
  input  logic             if_id_use2,
  input  logic             ex_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_wr,
  output logic             if_id_wr,
  output logic             id_ex_wr,
  output logic             ex_mem_wr,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned BC_W = 3;

  typedef enum logic {ST_RUN = 1'b0, ST_LU_STALL = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BC_W-1:0]   r_bcnt;
  logic [BC_W-1:0]   w_bcnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_lu_hit;
  logic              w_mem_wait;
  logic              w_bubble;

  // Hazard detection: only a load writing a nonzero register read by ID stalls
  assign w_lu_hit = id_ex_mr & id_ex_rw & (id_ex_rd != '0) &
                    ((if_id_use1 & (id_ex_rd == if_id_rs1)) |
                     (if_id_use2 & (id_ex_rd == if_id_rs2)));
  assign w_mem_wait = dmem_req & ~dmem_ready;
  assign w_bubble   = ((r_state == ST_RUN) & w_lu_hit) | (r_state == ST_LU_STALL);

  // Stage controls by priority: reset, freeze, branch, load-use bubble, normal
  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    id_ex_wr     = 1'b1;
    ex_mem_wr    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rstn) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_wr     = 1'b0;
      ex_mem_wr    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (w_mem_wait) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_wr     = 1'b0;
      ex_mem_wr    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_br_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (w_bubble) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // Next state: freeze holds everything, a branch aborts any pending bubbles
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    if (w_mem_wait) begin
      w_state_nxt = r_state;
      w_bcnt_nxt  = r_bcnt;
    end else if (ex_br_taken) begin
      w_state_nxt = ST_RUN;
      w_bcnt_nxt  = '0;
    end else if (r_state == ST_RUN) begin
      if (w_lu_hit && (LOAD_LAT > 1)) begin
        w_state_nxt = ST_LU_STALL;
        w_bcnt_nxt  = BC_W'(LOAD_LAT - 1);
      end
    end else begin
      if (r_bcnt <= BC_W'(1)) begin
        w_state_nxt = ST_RUN;
        w_bcnt_nxt  = '0;
      end else begin
        w_bcnt_nxt  = r_bcnt - BC_W'(1);
      end
    end
  end

  // State and bubble counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RUN;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Saturating count of cycles with the PC held; clear wins over increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (!pc_wr && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven vectors on a LOAD_LAT=1 instance, then directed
// multi-cycle sequences on a LOAD_LAT=3 / CNT_W=4 instance.
module tb_hazard_ctrl;

  localparam logic [6:0] O_RUN = 7'b1111000;
  localparam logic [6:0] O_BUB = 7'b0011010;
  localparam logic [6:0] O_FRZ = 7'b0000001;
  localparam logic [6:0] O_BR  = 7'b1111110;
  localparam logic [6:0] O_RST = 7'b0000111;

  typedef struct packed {
    logic       mr;
    logic       rw;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       mr, rw, u1, u2, br, req, rdy, clr;
  logic [4:0] rd, rs1, rs2;

  logic        a_pc, a_ifw, a_idw, a_exw, a_iff, a_idf, a_mwf;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifw, b_idw, b_exw, b_iff, b_idf, b_mwf;
  logic [3:0]  b_cnt;
  logic [6:0]  a_out, b_out;

  int checks = 0;
  int failures = 0;
  vec_t vecs [12];

  assign a_out = {a_pc, a_ifw, a_idw, a_exw, a_iff, a_idf, a_mwf};
  assign b_out = {b_pc, b_ifw, b_idw, b_exw, b_iff, b_idf, b_mwf};

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(5), .LOAD_LAT(1), .CNT_W(16)) u_a (
    .clk(clk), .rstn(rstn), .id_ex_mr(mr), .id_ex_rw(rw), .id_ex_rd(rd),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_use1(u1), .if_id_use2(u2),
    .ex_br_taken(br), .dmem_req(req), .dmem_ready(rdy), .cnt_clr(clr),
    .pc_wr(a_pc), .if_id_wr(a_ifw), .id_ex_wr(a_idw), .ex_mem_wr(a_exw),
    .if_id_flush(a_iff), .id_ex_flush(a_idf), .mem_wb_flush(a_mwf),
    .stall_cnt(a_cnt)
  );

  hazard_ctrl #(.RA_W(5), .LOAD_LAT(3), .CNT_W(4)) u_b (
    .clk(clk), .rstn(rstn), .id_ex_mr(mr), .id_ex_rw(rw), .id_ex_rd(rd),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_use1(u1), .if_id_use2(u2),
    .ex_br_taken(br), .dmem_req(req), .dmem_ready(rdy), .cnt_clr(clr),
    .pc_wr(b_pc), .if_id_wr(b_ifw), .id_ex_wr(b_idw), .ex_mem_wr(b_exw),
    .if_id_flush(b_iff), .id_ex_flush(b_idf), .mem_wb_flush(b_mwf),
    .stall_cnt(b_cnt)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic idle();
    mr = 1'b0; rw = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    u1 = 1'b0; u2 = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0; clr = 1'b0;
  endtask

  // load in EX writing r5, ID reads r5 through rs1
  task automatic hazard();
    mr = 1'b1; rw = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0; u1 = 1'b1; u2 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    #1 rstn = 1'b0;
    #2;
    chk("reset_out_a", int'(a_out), int'(O_RST));
    chk("reset_out_b", int'(b_out), int'(O_RST));
    chk("reset_cnt_a", int'(a_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // mr rw rd rs1 rs2 u1 u2 br req rdy exp
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[1]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_BUB};
    vecs[2]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[3]  = '{1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[4]  = '{1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BUB};
    vecs[5]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[6]  = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[7]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[8]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ};
    vecs[9]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ};
    vecs[11] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};

    // LOAD_LAT=1 instance never leaves RUN, so each vector stands alone
    for (int i = 0; i < 12; i++) begin
      mr = vecs[i].mr; rw = vecs[i].rw; rd = vecs[i].rd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; u1 = vecs[i].u1; u2 = vecs[i].u2;
      br = vecs[i].br; req = vecs[i].req; rdy = vecs[i].rdy;
      #2;
      chk($sformatf("vec%0d_out_a", i), int'(a_out), int'(vecs[i].exp));
      tick();
    end
    idle();
    #2;
    chk("vec_cnt_a", int'(a_cnt), 4);

    // basic load-use, LOAD_LAT=1: exactly one bubble
    do_reset();
    hazard();
    #2 chk("basic_bub_a", int'(a_out), int'(O_BUB));
    tick();
    idle();
    #2 chk("basic_after_a", int'(a_out), int'(O_RUN));
    chk("basic_cnt_a", int'(a_cnt), 1);
    tick();
    #2 chk("basic_cnt_hold_a", int'(a_cnt), 1);

    // LOAD_LAT=3 with a two-cycle memory wait inside the second bubble
    do_reset();
    hazard();
    #2 chk("mc_bub1_b", int'(b_out), int'(O_BUB));
    tick();
    req = 1'b1; rdy = 1'b0;
    #2 chk("mc_frz1_b", int'(b_out), int'(O_FRZ));
    tick();
    #2 chk("mc_frz2_b", int'(b_out), int'(O_FRZ));
    tick();
    rdy = 1'b1;
    #2 chk("mc_bub2_b", int'(b_out), int'(O_BUB));
    tick();
    req = 1'b0; rdy = 1'b0;
    #2 chk("mc_bub3_b", int'(b_out), int'(O_BUB));
    tick();
    idle();
    #2 chk("mc_run_b", int'(b_out), int'(O_RUN));
    chk("mc_cnt_b", int'(b_cnt), 5);

    // branch in the second LU_STALL cycle aborts the remaining bubbles
    do_reset();
    hazard();
    #2 chk("br_bub1_b", int'(b_out), int'(O_BUB));
    tick();
    #2 chk("br_bub2_b", int'(b_out), int'(O_BUB));
    tick();
    br = 1'b1;
    #2 chk("br_abort_b", int'(b_out), int'(O_BR));
    tick();
    idle();
    #2 chk("br_run1_b", int'(b_out), int'(O_RUN));
    tick();
    #2 chk("br_run2_b", int'(b_out), int'(O_RUN));

    // freeze beats branch beats load-use; branch serviced once unfrozen
    do_reset();
    hazard();
    br = 1'b1; req = 1'b1; rdy = 1'b0;
    #2 chk("prio_frz_b", int'(b_out), int'(O_FRZ));
    chk("prio_frz_a", int'(a_out), int'(O_FRZ));
    tick();
    rdy = 1'b1;
    #2 chk("prio_br_b", int'(b_out), int'(O_BR));
    tick();
    idle();
    #2 chk("prio_run_b", int'(b_out), int'(O_RUN));

    // counter saturation and clear priority
    do_reset();
    req = 1'b1; rdy = 1'b0;
    repeat (20) tick();
    #1 chk("sat_cnt_b", int'(b_cnt), 15);
    chk("sat_cnt_a", int'(a_cnt), 20);
    clr = 1'b1;
    tick();
    #1 chk("clr_cnt_b", int'(b_cnt), 0);
    chk("clr_cnt_a", int'(a_cnt), 0);
    idle();

    // reset mid-stall: immediate reset outputs, then clean RUN
    do_reset();
    hazard();
    tick();
    #2 chk("rst_stall_b", int'(b_out), int'(O_BUB));
    rstn = 1'b0;
    #1 chk("rst_mid_out_b", int'(b_out), int'(O_RST));
    chk("rst_mid_cnt_b", int'(b_cnt), 0);
    #1 rstn = 1'b1;
    idle();
    #1 chk("rst_rel_b", int'(b_out), int'(O_RUN));
    tick();
    #2 chk("rst_run_b", int'(b_out), int'(O_RUN));
    chk("rst_run_cnt_b", int'(b_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
